// File: rtl/uart_tx_buffered_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered_if
//  Purpose  : Core-side byte strobe plus transmitter status bundle for the
//             buffered UART transmitter.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_buffered_if #(
   parameter int DEPTH_LOG2 = 3
);
   logic                  tx_ready;
   logic [7:0]            sdata;
   logic                  txd;
   logic                  busy;
   logic                  full;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;

   // The core issues bytes and observes status.
   modport master (
      output tx_ready, sdata,
      input  txd, busy, full, level, overflow
   );

   // The transmitter consumes bytes and reports status.
   modport slave (
      input  tx_ready, sdata,
      output txd, busy, full, level, overflow
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered
//  Purpose  : 8N1 UART transmitter fed by a 2**DEPTH_LOG2-byte circular FIFO.
//             Back-to-back frames are sent with no idle gap.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_buffered #(
   parameter int CLK_PER_BIT = 868,
   parameter int DEPTH_LOG2  = 3
) (
   input  logic              clk,
   input  logic              rstn,
   uart_tx_buffered_if.slave bus
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int LW     = DEPTH_LOG2 + 1;
   localparam int PW     = DEPTH_LOG2;
   localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

   localparam logic [LW-1:0]     LEVEL_FULL = LW'(DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLK_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO state
   logic [7:0]        mem_q [DEPTH];
   logic [PW-1:0]     wptr_q;
   logic [PW-1:0]     rptr_q;
   logic [LW-1:0]     level_q;
   logic              overflow_q;

   // Serializer state
   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q,  baud_d;
   logic [2:0]        bit_q,   bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              txd_q,   txd_d;

   logic              pop;
   logic              push;
   logic              drop;
   logic              baud_end;
   logic              fifo_nonempty;
   logic [7:0]        rdata;

   assign fifo_nonempty = (level_q != '0);
   assign baud_end      = (baud_q == BAUD_LAST);
   assign rdata         = mem_q[rptr_q];

   // A pop frees a slot on the same edge, so a push into a full FIFO is
   // still accepted when the serializer is taking a byte.
   assign push = bus.tx_ready && ((level_q != LEVEL_FULL) || pop);
   assign drop = bus.tx_ready && (level_q == LEVEL_FULL) && !pop;

   // Byte storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= bus.sdata;
      end
   end

   // Pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Serializer registers; txd comes straight from a flop.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   // Serializer next-state: each state's txd value is loaded on the edge
   // that enters it, so frame boundaries carry no extra cycle.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      pop     = 1'b0;

      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (fifo_nonempty) begin
               pop     = 1'b1;
               shift_d = rdata;
               txd_d   = 1'b0;
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               txd_d   = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (fifo_nonempty) begin
                  pop     = 1'b1;
                  shift_d = rdata;
                  txd_d   = 1'b0;
                  state_d = START;
               end else begin
                  txd_d   = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            txd_d   = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.txd      = txd_q;
   assign bus.busy     = (state_q != IDLE) || fifo_nonempty;
   assign bus.full     = (level_q == LEVEL_FULL);
   assign bus.level    = level_q;
   assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_buffered
//  Purpose  : Self-checking bench for uart_tx_buffered (CLK_PER_BIT=4,
//             DEPTH_LOG2=3): vector table, serial receiver with scoreboard,
//             and hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_buffered;

   localparam int CPB = 4;
   localparam int DL2 = 3;

   logic clk;
   logic rstn;

   uart_tx_buffered_if #(.DEPTH_LOG2(DL2)) bus ();

   uart_tx_buffered #(
      .CLK_PER_BIT (CPB),
      .DEPTH_LOG2  (DL2)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   int         frames   = 0;
   bit         mon_en   = 1'b0;
   bit         mon_busy = 1'b0;
   logic [7:0] sb[$];
   int         start_q[$];

   typedef struct {
      logic [7:0] data;
      logic       valid;
      int         exp_level;
      int         exp_busy;
   } vec_t;

   localparam int NV = 6;
   vec_t vecs[NV];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected serial level c cycles after the start bit begins.
   function automatic logic exp_bit(input logic [7:0] d, input int c);
      int k;
      k = c / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return d[k-1];
   endfunction

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((bus.busy !== 1'b0 || mon_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         checks++;
         failures++;
         $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", bus.busy, budget);
      end
   endtask

   // Serial receiver: samples each bit near its middle and checks the byte
   // against the oldest scoreboard entry.
   initial begin
      logic [7:0] rx;
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (mon_en && rstn && bus.txd === 1'b0) begin
            mon_busy = 1'b1;
            start_q.push_back(cyc);
            repeat (CPB + 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               rx[i] = bus.txd;
               if (i < 7) repeat (CPB) @(negedge clk);
            end
            repeat (CPB) @(negedge clk);
            check("rx_stop_bit", 32'(bus.txd), 1);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rx_unexpected: got byte %02h, required no frame", rx);
            end else begin
               exp = sb.pop_front();
               check("rx_byte", 32'(rx), 32'(exp));
            end
            frames++;
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int f0;
      int s0;
      int maxlvl;
      int n;

      vecs[0] = '{8'h55, 1'b1, 1, 1};
      vecs[1] = '{8'h00, 1'b1, 1, 1};
      vecs[2] = '{8'hFF, 1'b1, 1, 1};
      vecs[3] = '{8'h3C, 1'b0, 0, 0};
      vecs[4] = '{8'h80, 1'b1, 1, 1};
      vecs[5] = '{8'hB6, 1'b1, 1, 1};

      rstn         = 1'b0;
      bus.tx_ready = 1'b0;
      bus.sdata    = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_txd",      32'(bus.txd),      1);
      check("rst_busy",     32'(bus.busy),     0);
      check("rst_full",     32'(bus.full),     0);
      check("rst_level",    32'(bus.level),    0);
      check("rst_overflow", 32'(bus.overflow), 0);
      rstn   = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Single-byte vectors: latency, bit-exact waveform, busy release.
      for (int v = 0; v < NV; v++) begin
         bus.tx_ready = vecs[v].valid;
         bus.sdata    = vecs[v].data;
         if (vecs[v].valid) sb.push_back(vecs[v].data);
         @(negedge clk);
         bus.tx_ready = 1'b0;
         bus.sdata    = 8'hEE;
         check("vec_level", 32'(bus.level), 32'(vecs[v].exp_level));
         check("vec_busy",  32'(bus.busy),  32'(vecs[v].exp_busy));
         check("vec_txd_e0", 32'(bus.txd), 1);
         bad = 0;
         if (vecs[v].valid) begin
            for (int c = 0; c < 10 * CPB; c++) begin
               @(negedge clk);
               if (bus.txd !== exp_bit(vecs[v].data, c) || bus.busy !== 1'b1) bad++;
            end
            check("vec_frame_bits", 32'(bad), 0);
            @(negedge clk);
            check("vec_busy_fall", 32'(bus.busy), 0);
         end else begin
            repeat (5) begin
               @(negedge clk);
               if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.level !== '0) bad++;
            end
            check("vec_ignored", 32'(bad), 0);
         end
         wait_idle(100);
      end

      // Back-to-back pushes: no gap, level never above 1.
      f0 = frames;
      s0 = start_q.size();
      bus.tx_ready = 1'b1;
      bus.sdata    = 8'hA3;
      sb.push_back(8'hA3);
      @(negedge clk);
      check("b2b_level_e0", 32'(bus.level), 1);
      bus.sdata = 8'h0F;
      sb.push_back(8'h0F);
      @(negedge clk);
      bus.tx_ready = 1'b0;
      bus.sdata    = 8'hEE;
      maxlvl = int'(bus.level);
      n = 0;
      while (frames < f0 + 2 && n < 200) begin
         @(negedge clk);
         if (int'(bus.level) > maxlvl) maxlvl = int'(bus.level);
         n++;
      end
      check("b2b_frames", 32'(frames - f0), 2);
      check("b2b_level_peak", 32'(maxlvl), 1);
      if (start_q.size() >= s0 + 2)
         check("b2b_start_gap", 32'(start_q[s0+1] - start_q[s0]), 40);
      wait_idle(100);

      // Overflow: ten pushes, the tenth is dropped.
      f0 = frames;
      for (int i = 0; i < 10; i++) begin
         bus.tx_ready = 1'b1;
         bus.sdata    = 8'(i);
         if (i < 9) sb.push_back(8'(i));
         @(negedge clk);
      end
      bus.tx_ready = 1'b0;
      bus.sdata    = 8'hEE;
      check("ovf_full",  32'(bus.full),     1);
      check("ovf_level", 32'(bus.level),    8);
      check("ovf_flag",  32'(bus.overflow), 1);
      wait_idle(600);
      check("ovf_sticky",       32'(bus.overflow), 1);
      check("ovf_drained_lvl",  32'(bus.level),    0);
      check("ovf_frames",       32'(frames - f0),  9);
      check("ovf_sb_empty",     32'(sb.size()),    0);

      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("rst_clears_ovf", 32'(bus.overflow), 0);
      @(negedge clk);

      // Wrap-around: four bursts of five.
      f0 = frames;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 5; i++) begin
            bus.tx_ready = 1'b1;
            bus.sdata    = 8'((b * 5 + i) * 37 + 1);
            sb.push_back(8'((b * 5 + i) * 37 + 1));
            @(negedge clk);
         end
         bus.tx_ready = 1'b0;
         bus.sdata    = 8'hEE;
         wait_idle(400);
      end
      check("wrap_frames",   32'(frames - f0), 20);
      check("wrap_sb_empty", 32'(sb.size()),   0);

      // Full FIFO with a push on the final STOP cycle of the first frame.
      f0 = frames;
      for (int i = 0; i < 9; i++) begin
         bus.tx_ready = 1'b1;
         bus.sdata    = 8'(8'hC0 + i);
         sb.push_back(8'(8'hC0 + i));
         @(negedge clk);
      end
      bus.tx_ready = 1'b0;
      bus.sdata    = 8'hEE;
      check("fpop_pre_level", 32'(bus.level), 8);
      repeat (32) @(negedge clk);
      bus.tx_ready = 1'b1;
      bus.sdata    = 8'h5E;
      sb.push_back(8'h5E);
      @(negedge clk);
      bus.tx_ready = 1'b0;
      bus.sdata    = 8'hEE;
      check("fpop_level",    32'(bus.level),    8);
      check("fpop_overflow", 32'(bus.overflow), 0);
      check("fpop_full",     32'(bus.full),     1);
      wait_idle(600);
      check("fpop_frames", 32'(frames - f0), 10);

      // Reset during DATA bit 3 aborts the frame and flushes the FIFO.
      mon_en = 1'b0;
      bus.tx_ready = 1'b1;
      bus.sdata    = 8'hA5;
      @(negedge clk);
      bus.sdata = 8'h11;
      @(negedge clk);
      bus.tx_ready = 1'b0;
      bus.sdata    = 8'hEE;
      repeat (16) @(negedge clk);
      check("rmid_bit3", 32'(bus.txd), 0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("rmid_txd",   32'(bus.txd),   1);
      check("rmid_busy",  32'(bus.busy),  0);
      check("rmid_level", 32'(bus.level), 0);
      @(negedge clk);
      mon_en = 1'b1;
      f0 = frames;
      bus.tx_ready = 1'b1;
      bus.sdata    = 8'h96;
      sb.push_back(8'h96);
      @(negedge clk);
      bus.tx_ready = 1'b0;
      bus.sdata    = 8'hEE;
      wait_idle(100);
      check("rmid_after_frames", 32'(frames - f0), 1);
      check("final_sb_empty",    32'(sb.size()),   0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
